// File: rtl/bcd_conv_arbiter_if.sv
// Bundle of the request and response channels around the shared binary-to-BCD engine.
// The master side belongs to the requesters and the consumer. The slave side belongs to the engine.
interface bcd_conv_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               resp_valid;
    logic               resp_ready;
    logic [11:0]        resp_bcd;
    logic [ID_W-1:0]    resp_id;
    logic               busy;

    modport master (
        output req_valid,
        output req_data,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_bcd,
        input  resp_id,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_bcd,
        output resp_id,
        output busy
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter in front of one iterative double-dabble converter.
// An 8-bit operand goes in, and 12-bit packed BCD {hundreds, tens, units} comes out.
// The engine processes one operand bit per clock.
// Each result returns on a valid/ready channel tagged with the owning requester index.
module bcd_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_conv_arbiter_if.slave     bus
);

    localparam int CW = ID_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [2:0]      count_q;
    logic [7:0]      operand_q;
    logic [3:0]      hun_q;
    logic [3:0]      ten_q;
    logic [3:0]      uni_q;
    logic [ID_W-1:0] owner_q;
    logic [11:0]     resp_bcd_q;
    logic [ID_W-1:0] resp_id_q;
    logic            resp_valid_q;
    logic            busy_q;

    // Arbitration results and the next-state values of the working registers.
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [7:0]      grant_data;
    logic [CW-1:0]   cand;
    logic            ready_en;
    logic [3:0]      hun_d;
    logic [3:0]      ten_d;
    logic [3:0]      uni_d;
    logic [7:0]      operand_d;

    // Double-dabble correction: a digit of 5 or more would exceed 9 after doubling.
    function automatic logic [3:0] adj(input logic [3:0] d);
        return (d > 4'd4) ? d + 4'd3 : d;
    endfunction

    // Round-robin search that starts at rr_ptr and takes the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!grant_found && bus.req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
                grant_data  = bus.req_data[8*cand[ID_W-1:0] +: 8];
            end
        end
    end

    // Grants exist only in IDLE and outside reset. Holding rst also kills the combinational path.
    assign ready_en = (state_q == IDLE) && !rst && grant_found;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = ready_en && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // One double-dabble iteration: adjust each digit, then shift the whole chain left by one.
    always_comb begin
        {hun_d, ten_d, uni_d, operand_d} = {adj(hun_q), adj(ten_q), adj(uni_q), operand_q} << 1;
    end

    // Control FSM. It holds the working registers and drives the registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            count_q      <= '0;
            operand_q    <= '0;
            hun_q        <= '0;
            ten_q        <= '0;
            uni_q        <= '0;
            owner_q      <= '0;
            resp_bcd_q   <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        operand_q <= grant_data;
                        hun_q     <= '0;
                        ten_q     <= '0;
                        uni_q     <= '0;
                        count_q   <= '0;
                        owner_q   <= grant_idx;
                        rr_ptr_q  <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    hun_q     <= hun_d;
                    ten_q     <= ten_d;
                    uni_q     <= uni_d;
                    operand_q <= operand_d;
                    count_q   <= count_q + 3'd1;
                    if (count_q == 3'd7) begin
                        resp_bcd_q   <= {hun_d, ten_d, uni_d};
                        resp_id_q    <= owner_q;
                        resp_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_bcd   = resp_bcd_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for the shared BCD converter.
// It covers table-driven single conversions, the round-robin stream, backpressure,
// asynchronous reset during a conversion, and a requester withdrawing before its grant.
module tb_bcd_conv_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcd_conv_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) vif ();

    bcd_conv_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          req;
        logic [7:0]  data;
        logic [11:0] bcd;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for resp_valid and count edges. Call it at #1 after an edge.
    task automatic wait_resp(output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        while (!got && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (vif.resp_valid) got = 1'b1;
        end
    endtask

    task automatic handshake();
        vif.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        vif.resp_ready = 1'b0;
    endtask

    // One complete transaction on requester r. Call it at #1 after an edge with the engine idle.
    task automatic run_one(input int r, input logic [7:0] d, input logic [11:0] exp_bcd);
        int n;
        vif.req_data[8*r +: 8] = d;
        vif.req_valid[r]       = 1'b1;
        #1;
        check("req_ready_grant", 32'(vif.req_ready), 32'(1) << r);
        @(posedge clk);
        #1;
        vif.req_valid[r] = 1'b0;
        check("busy_after_accept", 32'(vif.busy), 32'd1);
        wait_resp(n);
        check("latency", n, 32'd8);
        check("resp_bcd", 32'(vif.resp_bcd), 32'(exp_bcd));
        check("resp_id", 32'(vif.resp_id), r);
        $display("txn req=%0d data=%0d -> bcd=%03h id=%0d latency=%0d", r, d, vif.resp_bcd, vif.resp_id, n);
        handshake();
        check("resp_valid_drop", 32'(vif.resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] rr_bcd [4];
        int          cyc;
        int          last;
        int          nres;
        int          n;
        bit          seen;

        vecs[0] = '{0, 8'd255, 12'h255};
        vecs[1] = '{1, 8'd0,   12'h000};
        vecs[2] = '{1, 8'd9,   12'h009};
        vecs[3] = '{1, 8'd10,  12'h010};
        vecs[4] = '{1, 8'd99,  12'h099};
        vecs[5] = '{1, 8'd100, 12'h100};
        vecs[6] = '{1, 8'd128, 12'h128};
        rr_bcd[0] = 12'h011;
        rr_bcd[1] = 12'h022;
        rr_bcd[2] = 12'h033;
        rr_bcd[3] = 12'h044;

        // Reset state. Every requester is valid so the gating of the combinational ready can be checked.
        rst            = 1'b1;
        vif.req_valid  = '1;
        vif.req_data   = '0;
        vif.resp_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req_ready", 32'(vif.req_ready), 32'd0);
        check("rst_resp_valid", 32'(vif.resp_valid), 32'd0);
        check("rst_resp_bcd", 32'(vif.resp_bcd), 32'd0);
        check("rst_resp_id", 32'(vif.resp_id), 32'd0);
        check("rst_busy", 32'(vif.busy), 32'd0);
        vif.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table of single conversions.
        for (int i = 0; i < 7; i++) begin
            run_one(vecs[i].req, vecs[i].data, vecs[i].bcd);
        end

        // Round-robin stream after a fresh reset. The pointer starts at 0 and all requesters stay valid.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        vif.req_data   = {8'd44, 8'd33, 8'd22, 8'd11};
        vif.req_valid  = 4'hF;
        vif.resp_ready = 1'b1;
        #1;
        check("rr_first_ready", 32'(vif.req_ready), 32'd1);
        cyc  = 0;
        last = 0;
        nres = 0;
        while (nres < 8 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (vif.resp_valid) begin
                check("rr_id", 32'(vif.resp_id), nres % 4);
                check("rr_bcd", 32'(vif.resp_bcd), 32'(rr_bcd[nres % 4]));
                if (nres > 0) check("rr_interval", cyc - last, 32'd10);
                $display("txn rr#%0d id=%0d bcd=%03h cycle=%0d", nres, vif.resp_id, vif.resp_bcd, cyc);
                last = cyc;
                nres++;
            end
        end
        check("rr_count", nres, 32'd8);
        vif.req_valid = '0;
        @(posedge clk);
        #1;
        vif.resp_ready = 1'b0;

        // Backpressure on requester 2. Requester 0 competes but must not be granted while the result is pending.
        vif.req_data[23:16] = 8'd200;
        vif.req_valid[2]    = 1'b1;
        #1;
        check("bp_ready", 32'(vif.req_ready), 32'b0100);
        @(posedge clk);
        #1;
        vif.req_valid[2] = 1'b0;
        vif.req_valid[0] = 1'b1;
        check("bp_shift_ready", 32'(vif.req_ready), 32'd0);
        wait_resp(n);
        check("bp_latency", n, 32'd8);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(vif.resp_valid), 32'd1);
            check("bp_hold_bcd", 32'(vif.resp_bcd), 32'h200);
            check("bp_hold_id", 32'(vif.resp_id), 32'd2);
            check("bp_hold_ready", 32'(vif.req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        $display("txn req=2 data=200 -> bcd=%03h id=%0d held 5 cycles", vif.resp_bcd, vif.resp_id);
        handshake();
        vif.req_valid[0] = 1'b0;
        check("bp_done_valid", 32'(vif.resp_valid), 32'd0);
        check("bp_keep_bcd", 32'(vif.resp_bcd), 32'h200);
        check("bp_done_busy", 32'(vif.busy), 32'd0);

        // Asynchronous reset after four shift iterations. The pointer is 3, so requester 1 wins.
        vif.req_data[15:8] = 8'd77;
        vif.req_valid[1]   = 1'b1;
        #1;
        check("mid_rst_ready", 32'(vif.req_ready), 32'b0010);
        @(posedge clk);
        #1;
        vif.req_valid[1] = 1'b0;
        repeat (4) @(posedge clk);
        #4;
        vif.req_valid[3] = 1'b1;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(vif.busy), 32'd0);
        check("arst_resp_valid", 32'(vif.resp_valid), 32'd0);
        check("arst_resp_bcd", 32'(vif.resp_bcd), 32'd0);
        check("arst_resp_id", 32'(vif.resp_id), 32'd0);
        check("arst_req_ready", 32'(vif.req_ready), 32'd0);
        vif.req_valid[3] = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (vif.resp_valid) seen = 1'b1;
        end
        check("arst_no_resp", 32'(seen), 32'd0);
        vif.req_data[31:24] = 8'd99;
        vif.req_valid       = 4'b1001;
        #1;
        check("arst_ptr_zero", 32'(vif.req_ready), 32'b0001);
        vif.req_valid[3] = 1'b0;
        run_one(0, 8'd57, 12'h057);

        // Fairness: requester 2 withdraws before it is granted, so the pointer must skip it.
        vif.req_data[15:8]  = 8'd5;
        vif.req_data[23:16] = 8'd66;
        vif.req_valid       = 4'b0110;
        #1;
        check("fair_first_ready", 32'(vif.req_ready), 32'b0010);
        @(posedge clk);
        #1;
        vif.req_data[31:24] = 8'd123;
        vif.req_valid       = 4'b1000;
        wait_resp(n);
        check("fair_id1", 32'(vif.resp_id), 32'd1);
        check("fair_bcd1", 32'(vif.resp_bcd), 32'h005);
        $display("txn req=1 data=5 -> bcd=%03h id=%0d", vif.resp_bcd, vif.resp_id);
        handshake();
        check("fair_skip_ready", 32'(vif.req_ready), 32'b1000);
        @(posedge clk);
        #1;
        vif.req_valid = '0;
        wait_resp(n);
        check("fair_id3", 32'(vif.resp_id), 32'd3);
        check("fair_bcd3", 32'(vif.resp_bcd), 32'h123);
        $display("txn req=3 data=123 -> bcd=%03h id=%0d", vif.resp_bcd, vif.resp_id);
        handshake();
        check("fair_idle", 32'(vif.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
